uart_rx_fifo: RTL

Receive-side byte FIFO that sits directly downstream of the UART `receiver`. It captures every byte the receiver presents on `dataout` with its one-cycle `wr_EN` strobe. It buffers up to `DEPTH` bytes in the `rx_clk` domain until the host side pops them. The block reports occupancy and a sticky overflow condition so that bytes dropped on a full buffer are never silent.

---
 rtl/uart_rx_fifo.sv | 57 +++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive byte FIFO buffering receiver output until the host pops it
module uart_rx_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  rx_clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] datain,
   input  logic                  wr_EN,
   input  logic                  rd_EN,
   output logic [DATA_WIDTH-1:0] dataout,
   output logic                  rd_valid,
   output logic                  empty,
   output logic                  full,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   input  logic                  ovf_clr
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wptr, rptr;
   logic                  rd_acc, wr_acc, drop;

   // A read frees a slot in the same cycle, so a full FIFO can still take a write alongside it
   assign rd_acc = rd_EN && !empty;
   assign wr_acc = wr_EN && (!full || rd_acc);
   assign drop   = wr_EN && full && !rd_acc;
   assign empty  = count == '0;
   assign full   = count == (ADDR_WIDTH+1)'(DEPTH);

   // Storage array is deliberately left unreset
   always_ff @(posedge rx_clk)
      if (wr_acc) mem[wptr] <= datain;

   // Pointers, occupancy, registered read data and sticky overflow
   always_ff @(posedge rx_clk or negedge rst_n)
      if (!rst_n) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         dataout  <= '0;
         rd_valid <= 1'b0;
         overflow <= 1'b0;
      end else begin
         rd_valid <= rd_acc;
         if (wr_acc) wptr <= wptr + 1'b1;
         if (rd_acc) begin
            rptr    <= rptr + 1'b1;
            dataout <= mem[rptr];
         end
         count    <= (wr_acc && !rd_acc) ? count + 1'b1 :
                     (rd_acc && !wr_acc) ? count - 1'b1 : count;
         overflow <= drop ? 1'b1 : ovf_clr ? 1'b0 : overflow;
      end

endmodule
